// File: rtl/hu_hazard_if.sv
// Hazard-unit bundle: pipeline-register taps in, ALU operands and stage controls out.
// master = pipeline side, slave = hazard unit.
interface hu_hazard_if #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int MC_CNT_W = 6
);
  // decode stage
  logic [REG_AW-1:0]   Rs1_D, Rs2_D;
  logic                ren1_D, ren2_D;
  // execute stage
  logic [REG_AW-1:0]   Rs1_E, Rs2_E, Rd_E;
  logic                ren1_E, ren2_E, RegWrite_E, MemRead_E;
  logic [XLEN-1:0]     rdata1_E, rdata2_E, imme_E, PC_reg_E;
  logic                auipc_E, ALU_DB_Src_E;
  logic                mc_start_E;
  logic [MC_CNT_W-1:0] mc_cycles_E;
  logic                branch_taken_E;
  // memory stage
  logic                RegWrite_M, MemRead_M;
  logic [REG_AW-1:0]   Rd_M;
  logic [XLEN-1:0]     ALUResult_M;
  // writeback stage
  logic                RegWrite_W;
  logic [REG_AW-1:0]   Rd_W;
  logic [XLEN-1:0]     rdata_reg_W;
  // hazard unit results
  logic [XLEN-1:0]     ALU_DA, ALU_DB, Real_rdata2_E;
  logic [1:0]          fwd_sel1, fwd_sel2;
  logic                Stall_F, Stall_D, Stall_E;
  logic                Flush_D, Flush_E, Flush_M;
  logic                mc_busy;

  modport master (
    output Rs1_D, Rs2_D, ren1_D, ren2_D,
    output Rs1_E, Rs2_E, Rd_E, ren1_E, ren2_E, RegWrite_E, MemRead_E,
    output rdata1_E, rdata2_E, imme_E, PC_reg_E, auipc_E, ALU_DB_Src_E,
    output mc_start_E, mc_cycles_E, branch_taken_E,
    output RegWrite_M, MemRead_M, Rd_M, ALUResult_M,
    output RegWrite_W, Rd_W, rdata_reg_W,
    input  ALU_DA, ALU_DB, Real_rdata2_E, fwd_sel1, fwd_sel2,
    input  Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, mc_busy
  );

  modport slave (
    input  Rs1_D, Rs2_D, ren1_D, ren2_D,
    input  Rs1_E, Rs2_E, Rd_E, ren1_E, ren2_E, RegWrite_E, MemRead_E,
    input  rdata1_E, rdata2_E, imme_E, PC_reg_E, auipc_E, ALU_DB_Src_E,
    input  mc_start_E, mc_cycles_E, branch_taken_E,
    input  RegWrite_M, MemRead_M, Rd_M, ALUResult_M,
    input  RegWrite_W, Rd_W, rdata_reg_W,
    output ALU_DA, ALU_DB, Real_rdata2_E, fwd_sel1, fwd_sel2,
    output Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, mc_busy
  );
endinterface

// File: rtl/hu_hazard_ctrl.sv
// Hazard unit for the 5-stage pipeline: ALU operand forwarding, load-use
// interlock, branch flush and a multi-cycle execute interlock that freezes
// the captured operands while the op occupies E.
// Optional feature macro: HU_FORWARD_EN. When undefined, operands come
// straight from the register file and any D-stage read of a register still
// being written in E/M/W stalls decode until the write has retired.
module hu_hazard_ctrl #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int MC_CNT_W = 6
) (
  input logic        clk,
  input logic        rst,
  hu_hazard_if.slave hz
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [MC_CNT_W-1:0] CNT_ONE = MC_CNT_W'(1);
  localparam logic [MC_CNT_W-1:0] CNT_TWO = MC_CNT_W'(2);

  state_t              state_reg;
  logic [MC_CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0]     hold_da_reg, hold_db_reg, hold_rd2_reg;

  logic            busy;
  logic            mc_go;
  logic            mc_stall;
  logic            dep_hit;
  logic            lu_act;
  logic            br_act;
  logic [XLEN-1:0] live_da, live_db, live_rd2;

  assign busy = (state_reg == BUSY);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [REG_AW-1:0] rs_d;
      logic              ren_d;
      logic [XLEN-1:0]   rdata_e;
      logic [XLEN-1:0]   val;
      logic [1:0]        sel;
      logic              hit;

      assign rs_d    = (gi == 0) ? hz.Rs1_D    : hz.Rs2_D;
      assign ren_d   = (gi == 0) ? hz.ren1_D   : hz.ren2_D;
      assign rdata_e = (gi == 0) ? hz.rdata1_E : hz.rdata2_E;

`ifdef HU_FORWARD_EN
      logic [REG_AW-1:0] rs_e;
      logic              ren_e;
      assign rs_e  = (gi == 0) ? hz.Rs1_E  : hz.Rs2_E;
      assign ren_e = (gi == 0) ? hz.ren1_E : hz.ren2_E;

      // Operand select for this source: x0/unused read as zero, M beats W.
      always_comb begin
        val = rdata_e;
        sel = 2'd0;
        if (!ren_e || rs_e == '0) begin
          val = '0;
        end else if (hz.RegWrite_M && hz.Rd_M == rs_e) begin
          val = hz.ALUResult_M;
          sel = 2'd2;
        end else if (hz.RegWrite_W && hz.Rd_W == rs_e) begin
          val = hz.rdata_reg_W;
          sel = 2'd1;
        end
      end

      // Only a load result is too late to forward; flag decode reading it.
      always_comb begin
        hit = ren_d && hz.MemRead_E && hz.RegWrite_E &&
              (hz.Rd_E != '0) && (rs_d == hz.Rd_E);
      end
`else
      // Without forwarding the operand is whatever the register file gave.
      always_comb begin
        val = rdata_e;
        sel = 2'd0;
      end

      // Any in-flight write to a register decode reads must retire first.
      always_comb begin
        hit = ren_d && (rs_d != '0) &&
              ((hz.RegWrite_E && hz.Rd_E == rs_d) ||
               (hz.RegWrite_M && hz.Rd_M == rs_d) ||
               (hz.RegWrite_W && hz.Rd_W == rs_d));
      end
`endif
    end
  endgenerate

  // Live ALU operands before the multi-cycle hold mux.
  always_comb begin
    live_da  = hz.auipc_E ? hz.PC_reg_E : g_src[0].val;
    live_db  = hz.ALU_DB_Src_E ? g_src[1].val : hz.imme_E;
    live_rd2 = g_src[1].val;
  end

  // Stall/flush arbitration. The multi-cycle start cycle masks the data
  // interlock too, so Flush_E can never kill the op it is about to capture.
  always_comb begin
    mc_go    = !busy && hz.mc_start_E && (hz.mc_cycles_E >= CNT_TWO);
    mc_stall = mc_go || (busy && cnt_reg > CNT_ONE);
    dep_hit  = g_src[0].hit || g_src[1].hit;
    lu_act   = dep_hit && !busy && !mc_go;
    br_act   = hz.branch_taken_E && !busy;

    hz.Stall_F = mc_stall || (lu_act && !br_act);
    hz.Stall_D = mc_stall || (lu_act && !br_act);
    hz.Stall_E = mc_stall;
    hz.Flush_D = br_act;
    hz.Flush_E = br_act || lu_act;
    hz.Flush_M = mc_stall;
    hz.mc_busy = busy;

    hz.ALU_DA        = busy ? hold_da_reg  : live_da;
    hz.ALU_DB        = busy ? hold_db_reg  : live_db;
    hz.Real_rdata2_E = busy ? hold_rd2_reg : live_rd2;
    hz.fwd_sel1      = busy ? 2'd3 : g_src[0].sel;
    hz.fwd_sel2      = busy ? 2'd3 : g_src[1].sel;
  end

  // Multi-cycle FSM: capture operands on entry, count down the E occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      hold_da_reg  <= '0;
      hold_db_reg  <= '0;
      hold_rd2_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mc_go) begin
            cnt_reg      <= hz.mc_cycles_E - CNT_ONE;
            hold_da_reg  <= live_da;
            hold_db_reg  <= live_db;
            hold_rd2_reg <= live_rd2;
            state_reg    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_reg > CNT_ONE) begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end else begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Inputs that only matter in one build flavour, or not to this unit at all.
  logic unused_inputs;
  assign unused_inputs = ^{hz.MemRead_M, hz.MemRead_E, hz.ren1_E, hz.ren2_E,
                           hz.Rs1_E, hz.Rs2_E, hz.ALUResult_M, hz.rdata_reg_W};

endmodule

// File: doc/hu_hazard_ctrl.md
# hu_hazard_ctrl

Parametrised hazard unit for the 5-stage pipeline: operand forwarding for both ALU sources, load-use interlock, branch flush, and a multi-cycle execute interlock. For multi-cycle execute operations it holds the captured operands stable for the whole operation. Sits between the ID/EX/MEM/WB pipeline registers and the ALU input muxes, and drives all stall/flush controls.

## Interface
- XLEN, 32, datapath width
- REG_AW, 5, register-index width
- MC_CNT_W, 6, width of multi-cycle latency field
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- Rs1_D, Rs2_D  in  REG_AW  source indices in decode
- ren1_D, ren2_D  in  1  decode actually reads Rs1/Rs2
- Rs1_E, Rs2_E, Rd_E  in  REG_AW  execute indices
- ren1_E, ren2_E, RegWrite_E, MemRead_E  in  1  execute controls
- rdata1_E, rdata2_E, imme_E, PC_reg_E  in  XLEN  execute operands
- auipc_E, ALU_DB_Src_E  in  1  ALU A=PC / B=register select
- mc_start_E  in  1  execute holds a multi-cycle op
- mc_cycles_E  in  MC_CNT_W  its total E occupancy N
- branch_taken_E  in  1  branch/jump redirect resolved in E
- RegWrite_M, MemRead_M  in  1; Rd_M  in  REG_AW; ALUResult_M  in  XLEN
- RegWrite_W  in  1; Rd_W  in  REG_AW; rdata_reg_W  in  XLEN
- ALU_DA, ALU_DB  out  XLEN  ALU operands
- Real_rdata2_E  out  XLEN  forwarded rs2 (store data)
- fwd_sel1, fwd_sel2  out  2  0=RF, 1=W, 2=M, 3=hold buffer
- Stall_F, Stall_D, Stall_E  out  1  hold stage register
- Flush_D, Flush_E, Flush_M  out  1  insert bubble
- mc_busy  out  1  multi-cycle FSM in BUSY

## Operation
- Forwarding per source s∈{1,2}: if ren_s_E=0 → operand 0; else if Rs_s_E==0 → 0; else if RegWrite_M && Rd_M==Rs_s_E → ALUResult_M (sel 2); else if RegWrite_W && Rd_W==Rs_s_E → rdata_reg_W (sel 1); else rdata_s_E (sel 0). M strictly beats W.
- ALU_DA = auipc_E ? PC_reg_E : fwd1. ALU_DB = ALU_DB_Src_E ? fwd2 : imme_E. Real_rdata2_E = fwd2 always.
- Load-use: MemRead_E && RegWrite_E && Rd_E≠0 && ((ren1_D && Rs1_D==Rd_E) || (ren2_D && Rs2_D==Rd_E)) → Stall_F=Stall_D=1, Flush_E=1 for one cycle.
- Branch: branch_taken_E → Flush_D=Flush_E=1, Stall_F=Stall_D=0; branch overrides load-use in the same cycle.
- Multi-cycle FSM, states IDLE/BUSY, counter cnt (MC_CNT_W):
  - IDLE, mc_start_E, N≥2: Stall_F=Stall_D=Stall_E=1, Flush_M=1; capture ALU_DA/ALU_DB/Real_rdata2_E into hold regs; cnt←N−1; →BUSY.
  - IDLE, N∈{0,1}: single-cycle, no stall, no state change.
  - BUSY, cnt>1: same stalls and Flush_M; outputs driven from hold regs, fwd_selx=3; cnt←cnt−1.
  - BUSY, cnt==1: stalls released, outputs still from hold regs, Flush_M=0; →IDLE.
  - mc_start_E ignored while BUSY; load-use and branch detection masked while BUSY.
- Total E occupancy of a multi-cycle op = N cycles; stall cycles = N−1.

## Timing
- Forwarding, stall and flush outputs are combinational from current-cycle inputs and state; only FSM, cnt and hold regs are registered.
- Reset values: state=IDLE, cnt=0, hold regs=0, mc_busy=0; all stall/flush=0 absent hazards; fwd_sel from inputs.
- rst asserted mid-BUSY: next edge returns to IDLE, stalls drop in the cycle after reset deasserts.
- Hold regs guarantee operand stability while M/W drain and their forwarding sources disappear.

## Configuration
- HU_FORWARD_EN defined: forwarding as above.
- Undefined: no forwarding, fwd_selx ∈ {0,3}; operands come from rdata_s_E. The load-use rule is replaced by: any D-stage read (ren_s_D, Rs_s_D≠0) matching a writing Rd_E, Rd_M or Rd_W → Stall_F=Stall_D=1, Flush_E=1 until clear. The multi-cycle FSM and branch logic are unchanged.

## Test plan
- EX→EX: M writes x5=0x1234, W writes x5=0xAAAA, E reads x5 as rs1 → ALU_DA=0x1234, fwd_sel1=2.
- Load-use: lw x3 in E, add reading x3 in D → one cycle Stall_F/D=1, Flush_E=1; next cycle fwd_sel=1 with load data.
- x0 guard: RegWrite_M, Rd_M=0, ALUResult_M=0xFFFF, Rs1_E=0 → ALU_DA=0.
- Multi-cycle N=4 with operands 7 and 3; M/W change afterwards → 3 stall cycles, ALU_DA/DB stay 7/3, fwd_sel=3, mc_busy high for 3 cycles.
- Branch and load-use together → Flush_D=Flush_E=1, Stall_F=0.
- Without HU_FORWARD_EN: add x1; add x2,x1 back-to-back → D stalls 3 cycles until x1 leaves W; rst pulsed mid-BUSY → IDLE, cnt=0.
